// File: rtl/power_pkg.sv
// Shared power-state encodings for the car power controller.
package power_pkg;

   localparam int unsigned STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      OFF    = 2'd0,
      ARMING = 2'd1,
      ON     = 2'd2
   } power_state_t;

endpackage

// File: rtl/power_ctrl_if.sv
// Key/activity inputs and power status outputs of the power controller.
interface power_ctrl_if;
   import power_pkg::*;

   logic               power_on;
   logic               power_off_key;
   logic               activity;
   logic               car_enable;
   logic [STATE_W-1:0] power_state;
   logic               auto_off;

   modport master (
      output power_on, power_off_key, activity,
      input  car_enable, power_state, auto_off
   );

   modport slave (
      input  power_on, power_off_key, activity,
      output car_enable, power_state, auto_off
   );

endinterface

// File: rtl/key_debounce.sv
// Synchronizes a raw bouncy key, debounces it and pulses on its accepted rising edge.
module key_debounce #(
   parameter int unsigned STABLE_CYC = 2_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic rise
);

   localparam int unsigned CNT_W = $clog2(STABLE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CYC - 1);

   logic             sync1;
   logic             sync2;
   logic             level;
   logic [CNT_W-1:0] cnt;

   // Two-flop synchronizer for the asynchronous key.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= key;
         sync2 <= sync1;
      end
   end

   // Level flips only after STABLE_CYC consecutive cycles of disagreement.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
      end else begin
         rise <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_TERM) begin
            cnt   <= '0;
            level <= sync2;
            rise  <= sync2;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/power_ctrl.sv
// Car power-state controller: OFF -> ARMING -> ON, off key and idle auto power-down.
module power_ctrl
   import power_pkg::*;
#(
   parameter int unsigned IDLE_TIMEOUT_CYC = 500_000_000,
   parameter int unsigned OFF_DEBOUNCE_CYC = 2_000_000
) (
   input logic         clk,
   input logic         rst,
   power_ctrl_if.slave bus
);

   localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT_CYC);
   localparam logic [IDLE_W-1:0] IDLE_TERM = IDLE_W'(IDLE_TIMEOUT_CYC - 1);

   power_state_t      state_q;
   power_state_t      state_d;
   logic              auto_off_d;
   logic              power_on_q;
   logic              on_armed;
   logic              on_rise;
   logic              off_press;
   logic              idle_term;
   logic [IDLE_W-1:0] idle_q;

   key_debounce #(
      .STABLE_CYC (OFF_DEBOUNCE_CYC)
   ) u_off_key (
      .clk  (clk),
      .rst  (rst),
      .key  (bus.power_off_key),
      .rise (off_press)
   );

   // A rise needs power_on seen low since reset, so a key held through reset is ignored.
   assign on_rise   = bus.power_on & ~power_on_q & on_armed;
   assign idle_term = (idle_q == IDLE_TERM);

   // Power-on edge detect history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         power_on_q <= 1'b0;
         on_armed   <= 1'b0;
      end else begin
         power_on_q <= bus.power_on;
         if (!bus.power_on) begin
            on_armed <= 1'b1;
         end
      end
   end

   // State register and registered outputs, all updated on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= OFF;
         bus.car_enable  <= 1'b0;
         bus.power_state <= STATE_W'(OFF);
         bus.auto_off    <= 1'b0;
      end else begin
         state_q         <= state_d;
         bus.car_enable  <= (state_d == ARMING) || (state_d == ON);
         bus.power_state <= state_d;
         bus.auto_off    <= auto_off_d;
      end
   end

   // Idle counter: runs only across consecutive quiet ON cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_q <= '0;
      end else if ((state_q != ON) || bus.activity || (state_d != ON)) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_q + IDLE_W'(1);
      end
   end

   // Next-state logic; off_press outranks on_rise and the idle timeout.
   always_comb begin
      state_d    = state_q;
      auto_off_d = 1'b0;
      case (state_q)
         OFF: begin
            if (on_rise && !off_press) begin
               state_d = ARMING;
            end
         end
         ARMING: begin
            if (off_press) begin
               state_d = OFF;
            end else if (!bus.power_on) begin
               state_d = ON;
            end
         end
         ON: begin
            if (off_press) begin
               state_d = OFF;
            end else if (idle_term && !bus.activity) begin
               state_d    = OFF;
               auto_off_d = 1'b1;
            end
         end
         default: begin
            state_d = OFF;
         end
      endcase
   end

endmodule

// File: tb/tb_power_ctrl.sv
// Directed bench for power_ctrl with IDLE_TIMEOUT_CYC=20, OFF_DEBOUNCE_CYC=4.
module tb_power_ctrl;
   import power_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   power_ctrl_if bus ();

   power_ctrl #(
      .IDLE_TIMEOUT_CYC (20),
      .OFF_DEBOUNCE_CYC (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic       po;
      logic       key;
      logic       act;
      logic [1:0] st;
      logic       en;
      logic       ao;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic chk_out(input string tag, input logic [1:0] st, input logic en, input logic ao);
      chk({tag, ".power_state"}, 32'(bus.power_state), 32'(st));
      chk({tag, ".car_enable"},  32'(bus.car_enable),  32'(en));
      chk({tag, ".auto_off"},    32'(bus.auto_off),    32'(ao));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void add(input logic po, input logic key, input logic act,
                               input logic [1:0] st, input logic en, input logic ao);
      vec_t v;
      v.po = po; v.key = key; v.act = act; v.st = st; v.en = en; v.ao = ao;
      vecs.push_back(v);
   endfunction

   // From OFF with power_on low: one-cycle press then release reaches ON.
   task automatic go_on(input string tag);
      bus.power_on = 1'b1;
      tick();
      chk_out({tag, ".arm"}, ARMING, 1'b1, 1'b0);
      bus.power_on = 1'b0;
      tick();
      chk_out({tag, ".on"}, ON, 1'b1, 1'b0);
   endtask

   initial begin
      #100_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst               = 1'b1;
      bus.power_on      = 1'b0;
      bus.power_off_key = 1'b0;
      bus.activity      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_out("reset", OFF, 1'b0, 1'b0);
      rst = 1'b0;

      // Scenario 1 + 2a: power-on sequence then idle timeout, cycle-by-cycle.
      for (int c = 0; c <= 9; c++)   add(1'b0, 1'b0, 1'b0, OFF,    1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, OFF, 1'b0, 1'b0);
      for (int c = 11; c <= 14; c++) add(1'b1, 1'b0, 1'b0, ARMING, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b0, ARMING, 1'b1, 1'b0);
      for (int c = 16; c <= 35; c++) add(1'b0, 1'b0, 1'b0, ON,     1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b0, OFF, 1'b0, 1'b1);
      add(1'b0, 1'b0, 1'b0, OFF, 1'b0, 1'b0);

      foreach (vecs[i]) begin
         chk_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].en, vecs[i].ao);
         bus.power_on      = vecs[i].po;
         bus.power_off_key = vecs[i].key;
         bus.activity      = vecs[i].act;
         tick();
      end

      // Scenario 2b: activity on the terminal cycle restarts the idle count.
      go_on("t2b");
      for (int k = 2; k <= 20; k++) begin
         tick();
         chk_out($sformatf("t2b.c%0d", k), ON, 1'b1, 1'b0);
      end
      bus.activity = 1'b1;
      tick();
      chk_out("t2b.c21", ON, 1'b1, 1'b0);
      bus.activity = 1'b0;
      for (int k = 22; k <= 40; k++) begin
         tick();
         chk_out($sformatf("t2b.c%0d", k), ON, 1'b1, 1'b0);
      end
      tick();
      chk_out("t2b.timeout", OFF, 1'b0, 1'b1);
      tick();
      chk_out("t2b.after", OFF, 1'b0, 1'b0);

      // Scenario 3: bouncy off key while active in ON.
      go_on("t3");
      bus.activity = 1'b1;
      for (int b = 0; b < 8; b++) begin
         bus.power_off_key = ~b[1];
         tick();
         chk_out($sformatf("t3.bounce%0d", b), ON, 1'b1, 1'b0);
      end
      bus.power_off_key = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk_out($sformatf("t3.wait%0d", k), ON, 1'b1, 1'b0);
      end
      tick();
      chk_out("t3.off", OFF, 1'b0, 1'b0);
      bus.power_off_key = 1'b0;
      bus.activity      = 1'b0;
      repeat (10) tick();
      chk_out("t3.settled", OFF, 1'b0, 1'b0);

      // Scenario 4: power_on held high through reset release.
      rst          = 1'b1;
      bus.power_on = 1'b1;
      tick();
      tick();
      chk_out("t4.reset", OFF, 1'b0, 1'b0);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk_out($sformatf("t4.held%0d", k), OFF, 1'b0, 1'b0);
      end
      bus.power_on = 1'b0;
      tick();
      chk_out("t4.low", OFF, 1'b0, 1'b0);
      go_on("t4");

      // Scenario 5: second press ignored in ON; off press on idle terminal cycle.
      for (int c = 1; c <= 20; c++) begin
         chk_out($sformatf("t5.c%0d", c), ON, 1'b1, 1'b0);
         bus.power_on      = (c >= 3) && (c <= 8);
         bus.power_off_key = (c >= 14);
         tick();
      end
      chk_out("t5.off", OFF, 1'b0, 1'b0);
      tick();
      chk_out("t5.after", OFF, 1'b0, 1'b0);
      bus.power_off_key = 1'b0;
      repeat (10) tick();

      // Scenario 6: asynchronous reset while ON, then a fresh power-on.
      go_on("t6");
      repeat (3) tick();
      chk_out("t6.on", ON, 1'b1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk_out("t6.async", OFF, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk_out($sformatf("t6.wait%0d", k), OFF, 1'b0, 1'b0);
      end
      go_on("t6.again");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
